// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with a two-digit key history.
// Columns are driven one-hot-low in turn. A single closed key stops the
// scan, and the key is committed into value2 (the old value2 moves to
// value1) with a one-cycle new_key pulse. The scan resumes once the key
// is released.
//
// Build option: define KEYPAD_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable
// samples before a press or a release is accepted. Without it, a press
// commits one cycle after detection and the first all-high sample ends a
// hold. DEBOUNCE_CYCLES has no effect in that build.
// state_dbg exposes the FSM state register for observation.
module keypad_scanner #(
    parameter int SCAN_DIV        = 20000,
    parameter int DEBOUNCE_CYCLES = 400000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] value1,
    output logic [3:0] value2,
    output logic       new_key,
    output logic [1:0] state_dbg
);

    // Reject parameter values the timing arithmetic below cannot support.
    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("keypad_scanner: need SCAN_DIV >= 4 and DEBOUNCE_CYCLES >= 2");
    end

    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

`ifdef KEYPAD_DEBOUNCE_EN
    // The detection (or first all-high) cycle is the first stable sample, so
    // the counter only has to cover the remaining DEBOUNCE_CYCLES-1 samples.
    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES - 1) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    logic [DW-1:0] deb_cnt;
    logic [3:0]    lat_rows;
    logic [3:0]    pend_code;
`else
    typedef enum logic [1:0] {
        SCAN = 2'd0,
        HELD = 2'd2
    } state_t;
`endif

    state_t        state;
    logic [1:0]    col;
    logic [1:0]    next_col;
    logic [SW-1:0] dwell;
    logic [3:0]    rs_meta;
    logic [3:0]    rs;
    logic          one_low;
    logic [1:0]    low_row;
    logic [3:0]    key_code;

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
        endcase
        return code;
    endfunction

    assign next_col  = col + 2'd1;
    assign key_code  = decode_key(low_row, col);
    assign state_dbg = state;

    // Two-flop synchronizer for the asynchronous row lines; idle is all high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_meta <= 4'b1111;
            rs      <= 4'b1111;
        end else begin
            rs_meta <= rows;
            rs      <= rs_meta;
        end
    end

    // Exactly one low row is a candidate press; anything else is ignored.
    always_comb begin
        one_low = 1'b1;
        low_row = 2'd0;
        case (rs)
            4'b1110: low_row = 2'd0;
            4'b1101: low_row = 2'd1;
            4'b1011: low_row = 2'd2;
            4'b0111: low_row = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    // Scan / debounce / hold state machine with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            col       <= 2'd0;
            cols      <= 4'b1110;
            dwell     <= '0;
            value1    <= 4'h0;
            value2    <= 4'h0;
            new_key   <= 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
            deb_cnt   <= '0;
            lat_rows  <= 4'b1111;
            pend_code <= 4'h0;
`endif
        end else begin
            new_key <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == SCAN_LAST) begin
                        dwell <= '0;
                        if (one_low) begin
`ifdef KEYPAD_DEBOUNCE_EN
                            lat_rows  <= rs;
                            pend_code <= key_code;
                            deb_cnt   <= '0;
                            state     <= DEBOUNCE;
`else
                            value1  <= value2;
                            value2  <= key_code;
                            new_key <= 1'b1;
                            state   <= HELD;
`endif
                        end else begin
                            col  <= next_col;
                            cols <= col_drive(next_col);
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
`ifdef KEYPAD_DEBOUNCE_EN
                DEBOUNCE: begin
                    if (rs != lat_rows) begin
                        state <= SCAN;
                        dwell <= '0;
                        col   <= next_col;
                        cols  <= col_drive(next_col);
                    end else if (deb_cnt == DEB_LAST) begin
                        value1  <= value2;
                        value2  <= pend_code;
                        new_key <= 1'b1;
                        state   <= HELD;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (rs == 4'b1111) begin
                        deb_cnt <= '0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (rs != 4'b1111) begin
                        state <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state <= SCAN;
                        dwell <= '0;
                        col   <= next_col;
                        cols  <= col_drive(next_col);
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
`else
                HELD: begin
                    if (rs == 4'b1111) begin
                        state <= SCAN;
                        dwell <= '0;
                        col   <= next_col;
                        cols  <= col_drive(next_col);
                    end
                end
`endif
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner (SCAN_DIV=4,
// DEBOUNCE_CYCLES=8). A keypad model turns pressed keys plus the driven
// column into row levels. Expected key codes are queued when a key is
// pressed and checked, with their commit latency, when new_key pulses.
// Expectations follow KEYPAD_DEBOUNCE_EN when it is defined.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 8;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int LAT        = DC;
    localparam int EXP_PULSES = 4;
`else
    localparam int LAT        = 1;
    localparam int EXP_PULSES = 6;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] value1;
    logic [3:0] value2;
    logic       new_key;
    logic [1:0] state_dbg;

    logic [15:0] keys;
    logic [3:0]  exp_q[$];
    logic [3:0]  prev_cols;
    logic [3:0]  model_v1;
    int cyc    = 0;
    int tests  = 0;
    int fails  = 0;
    int pulses = 0;
    int t_col  = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .value1(value1), .value2(value2), .new_key(new_key), .state_dbg(state_dbg)
    );

    // Clock, cycle index and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within 20000 cycles");
        $fatal(1, "watchdog");
    end

    // Keypad model: a closed key pulls its row low while its column is driven.
    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    function automatic logic [3:0] drive(input int c);
        logic [3:0] v;
        v = 4'b1111;
        v[c % 4] = 1'b0;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic press(input int r, input int c);
        keys[r*4+c] = 1'b1;
    endtask

    task automatic lift(input int r, input int c);
        keys[r*4+c] = 1'b0;
    endtask

    task automatic wait_cols_change(input int budget, output int at);
        logic [3:0] start;
        int n;
        start = cols;
        n = 0;
        while (cols === start && n < budget) begin
            tick();
            n++;
        end
        check("cols_change_seen", 32'(cols !== start), 1);
        at = cyc;
    endtask

    task automatic wait_col_start(input int c, input int budget);
        int n;
        n = 0;
        while (!(cols === drive(c) && t_col == cyc) && n < budget) begin
            tick();
            n++;
        end
        check("col_start_seen", 32'(cols === drive(c) && t_col == cyc), 1);
    endtask

    // Scoreboard: tracks when the current column started, and on each pulse
    // pops the expected code and checks both digits and the commit latency.
    always @(negedge clk) begin
        if (!reset) begin
            t_col     = cyc;
            prev_cols = cols;
            model_v1  = 4'h0;
        end else begin
            if (cols !== prev_cols) begin
                t_col     = cyc;
                prev_cols = cols;
            end
            if (new_key === 1'b1) begin
                logic [3:0] e;
                pulses++;
                check("pulse_was_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("commit_value2", value2, e);
                    check("commit_value1", value1, model_v1);
                    check("commit_latency", cyc, t_col + SD - 1 + LAT);
                    model_v1 = e;
                end
            end
        end
    end

    initial begin
        int at, rel, t0;
        keys  = '0;
        reset = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("rst_cols", cols, 4'b1110);
        check("rst_value1", value1, 4'h0);
        check("rst_value2", value2, 4'h0);
        check("rst_new_key", new_key, 1'b0);

        // Idle scan: each column for SD cycles, wrapping 3 -> 0.
        reset = 1'b1;
        for (int j = 0; j < 20; j++) begin
            check("idle_scan_cols", cols, drive(j / SD));
            tick();
        end

        // Key 6 (row1, col2) held 50 cycles, then released.
        exp_q.push_back(4'h6);
        press(1, 2);
        repeat (50) tick();
        check("hold6_pulses", pulses, 1);
        check("hold6_value2", value2, 4'h6);
        check("hold6_value1", value1, 4'h0);
        lift(1, 2);
        rel = cyc;
        wait_cols_change(40, at);
        check("release6_resume_cycle", at, rel + 2 + LAT);
        check("release6_resume_col", cols, drive(3));

        // Key 7 then key D, released in between.
        exp_q.push_back(4'h7);
        press(2, 0);
        repeat (40) tick();
        lift(2, 0);
        repeat (30) tick();
        exp_q.push_back(4'hD);
        press(3, 3);
        repeat (40) tick();
        lift(3, 3);
        repeat (30) tick();
        check("seq_pulses", pulses, 3);
        check("seq_value1", value1, 4'h7);
        check("seq_value2", value2, 4'hD);

        // Key 5 held, 9 added, both released, 5 bounces during release.
        exp_q.push_back(4'h5);
        press(1, 1);
        t0 = 0;
        while (pulses < 4 && t0 < 60) begin
            tick();
            t0++;
        end
        check("hold5_pulse_seen", pulses, 4);
        repeat (5) tick();
        press(2, 2);
        repeat (10) tick();
        lift(1, 1);
        lift(2, 2);
        repeat (4) tick();
        press(1, 1);
        repeat (2) tick();
        lift(1, 1);
        rel = cyc;
`ifdef KEYPAD_DEBOUNCE_EN
        wait_cols_change(40, at);
        check("bounce_resume_cycle", at, rel + 2 + LAT);
`endif
        check("bounce_resume_col", cols, drive(2));
        repeat (20) tick();
        check("hold5_pulses", pulses, 4);
        check("hold5_value1", value1, 4'hD);
        check("hold5_value2", value2, 4'h5);

        // Key 2 (row0, col1) closed for only 3 cycles at the start of col1.
`ifndef KEYPAD_DEBOUNCE_EN
        exp_q.push_back(4'h2);
`endif
        wait_col_start(1, 40);
        press(0, 1);
        repeat (3) tick();
        lift(0, 1);
        repeat (2) tick();
        check("glitch_col_frozen", cols, drive(1));
        tick();
        check("glitch_next_col", cols, drive(2));
        repeat (20) tick();
`ifdef KEYPAD_DEBOUNCE_EN
        check("glitch_pulses", pulses, 4);
`else
        check("glitch_pulses", pulses, 5);
`endif

        // Key 1 pressed, reset asserted two cycles after detection.
`ifndef KEYPAD_DEBOUNCE_EN
        exp_q.push_back(4'h1);
`endif
        wait_col_start(0, 40);
        press(0, 0);
        repeat (5) tick();
        reset = 1'b0;
        lift(0, 0);
        #1;
        check("midrst_cols", cols, 4'b1110);
        check("midrst_value1", value1, 4'h0);
        check("midrst_value2", value2, 4'h0);
        check("midrst_new_key", new_key, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check("post_rst_scan_cols", cols, drive(j / SD));
            tick();
        end
        repeat (30) tick();
        check("post_rst_value1", value1, 4'h0);
        check("post_rst_value2", value2, 4'h0);
        check("total_pulses", pulses, EXP_PULSES);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
